// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with HI/LO registers (clk, reset active-low async, start/op/a/b in; busy/hi/lo out)
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi, pend_lo, num, den, den_nz, uq, ur, q, r;
  logic [63:0] mul;
  logic sgn, is_div, zero;
  always_comb begin
    sgn = !op[0];
    is_div = op[1];
    zero = b == 32'd0;
    num = sgn && a[31] ? -a : a;
    den = sgn && b[31] ? -b : b;
    den_nz = zero ? 32'd1 : den;
    uq = num / den_nz;
    ur = num % den_nz;
    q = sgn && (a[31] ^ b[31]) ? -uq : uq;
    r = sgn && a[31] ? -ur : ur;
    mul = sgn ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'd0, a} * {32'd0, b};
  end
  assign busy = cnt != '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start && !op[2]) begin
      {pend_hi, pend_lo} <= is_div ? (zero ? {hi, lo} : {r, q}) : mul;
      cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (start && op == 3'd4) hi <= a;
    else if (start && op == 3'd5) lo <= a;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed vector bench for mdu_hilo
module tb_mdu_hilo;
  logic clk = 0, reset = 0, start = 0, busy;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0, hi, lo;
  int nvec = 0, errs = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          n;
  } vec_t;
  vec_t v[17];

  mdu_hilo dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
                .busy(busy), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input vec_t t);
    logic [31:0] ph, pl;
    logic stable;
    int n;
    ph = hi; pl = lo; stable = 1;
    start = 1; op = t.op; a = t.a; b = t.b;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      if (hi !== ph || lo !== pl) stable = 0;
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d cycles", idx), n, t.n);
    chk($sformatf("v%0d stable", idx), {31'd0, stable}, 32'd1);
    chk($sformatf("v%0d hi", idx), hi, t.hi);
    chk($sformatf("v%0d lo", idx), lo, t.lo);
  endtask

  initial begin
    int n;
    v[0]  = '{3'd5, 32'h12345678, 32'h0, 32'h0, 32'h12345678, 0};
    v[1]  = '{3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    v[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    v[3]  = '{3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    v[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10};
    v[5]  = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10};
    v[6]  = '{3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10};
    v[7]  = '{3'd4, 32'd5, 32'h0, 32'd5, 32'hFFFFFFFD, 0};
    v[8]  = '{3'd5, 32'd6, 32'h0, 32'd5, 32'd6, 0};
    v[9]  = '{3'd3, 32'd100, 32'h0, 32'd5, 32'd6, 10};
    v[10] = '{3'd2, 32'hFFFFFFF8, 32'h0, 32'd5, 32'd6, 10};
    v[11] = '{3'd6, 32'd1, 32'd1, 32'd5, 32'd6, 0};
    v[12] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    v[13] = '{3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 5};
    v[14] = '{3'd1, 32'h80000000, 32'd2, 32'd1, 32'h0, 5};
    v[15] = '{3'd3, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999, 10};
    v[16] = '{3'd7, 32'hAAAA5555, 32'd3, 32'd5, 32'h19999999, 0};
    #2;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) run_op(i, v[i]);
    start = 1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    start = 1; op = 3'd4; a = 32'hDEADBEEF;
    @(posedge clk); #1;
    op = 3'd2; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("ignored cycles", n, 2);
    chk("ignored hi", hi, 32'd0);
    chk("ignored lo", lo, 32'd12);
    @(posedge clk); #1;
    chk("ignored not queued", {31'd0, busy}, 32'd0);
    start = 1; op = 3'd2; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #3 reset = 0;
    #1;
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset hi", hi, 32'd0);
    chk("mid reset lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1;
    repeat (12) @(posedge clk);
    #1;
    chk("discarded busy", {31'd0, busy}, 32'd0);
    chk("discarded hi", hi, 32'd0);
    chk("discarded lo", lo, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
